// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a shared external 8x8 multiplier.
// Holds the granted operands on the multiplier for SETTLE_CYCLES edges, then captures the product.
module mult_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic [7:0]  mul_in1,
  output logic [7:0]  mul_in2,
  input  logic [15:0] mul_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               op_id;
  logic               last_id;
  logic               grant;

  // Round-robin only matters on a tie; a lone requester always wins.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last_id;
  end

  assign req0_ready = !reset && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = !reset && (state == IDLE) && req1_valid && grant;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_id     <= 1'b0;
      last_id   <= 1'b1;
      mul_in1   <= '0;
      mul_in2   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            mul_in1 <= req0_a;
            mul_in2 <= req0_b;
            op_id   <= 1'b0;
            last_id <= 1'b0;
            cnt     <= CNT_W'(SETTLE_CYCLES);
            state   <= CALC;
          end else if (req1_ready) begin
            mul_in1 <= req1_a;
            mul_in2 <= req1_b;
            op_id   <= 1'b1;
            last_id <= 1'b1;
            cnt     <= CNT_W'(SETTLE_CYCLES);
            state   <= CALC;
          end
        end
        CALC: begin
          // Capture on the edge where the settle count expires.
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            rsp_data  <= mul_out;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: SETTLE_CYCLES, 1, cycles operands are held on the shared multiplier before its product is captured (legal range 1..15).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req0_valid  in  1  requester 0 has an operand pair.
REQ-006 req0_ready  out  1  requester 0 operands accepted this edge.
REQ-007 req0_a, req0_b  in  8 each  requester 0 unsigned operands.
REQ-008 req1_valid, req1_ready, req1_a, req1_b  same as REQ-005..007 for requester 1.
REQ-009 mul_in1, mul_in2  out  8 each  operands driven to the shared 8x8 Wallace multiplier (IN1/IN2).
REQ-010 mul_out  in  16  combinational product returned by the shared multiplier (OUT).
REQ-011 rsp_valid  out  1  result available.
REQ-012 rsp_ready  in  1  consumer accepts result.
REQ-013 rsp_id  out  1  requester index that owns rsp_data.
REQ-014 rsp_data  out  16  captured unsigned product.
REQ-015 busy  out  1  high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, CALC, RESP.
REQ-017 Grant in IDLE: only req0 valid -> 0; only req1 valid -> 1; both valid -> requester other than last_id (round-robin).
REQ-018 reqN_ready SHALL be combinational, high only when state==IDLE and grant==N; it SHALL be low in CALC and RESP.
REQ-019 Accept edge (reqN_valid && reqN_ready): latch operands into op registers, latch id, set last_id=N, load settle counter with SETTLE_CYCLES, go CALC.
REQ-020 mul_in1/mul_in2 SHALL be driven only from the op registers (registered, glitch-free); they keep the last operands in IDLE and RESP.
REQ-021 CALC: counter decrements each edge; on the edge where it reaches 0, rsp_data<=mul_out, rsp_id<=latched id, rsp_valid<=1, go RESP.
REQ-022 Latency: rsp_valid SHALL rise exactly SETTLE_CYCLES edges after the accept edge.
REQ-023 rsp_data SHALL be mul_out unmodified (16-bit unsigned, no truncation, no recomputation).
REQ-024 RESP: rsp_valid, rsp_id and rsp_data SHALL remain stable until rsp_ready is high at an edge; on that edge rsp_valid<=0, go IDLE.
REQ-025 No new request is accepted on the response-handshake edge; the earliest next accept is the following edge (one op per SETTLE_CYCLES+2 cycles minimum).
REQ-026 A requester that drops valid before its accept edge SHALL be ignored; operand changes before acceptance have no effect.
REQ-027 rsp_ready while not in RESP SHALL be ignored.

Reset
REQ-028 reset high SHALL immediately force: state=IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, mul_in1=0, mul_in2=0, busy=0, counter=0, last_id=1 (requester 0 wins the first tie).
REQ-029 Reset during CALC or RESP SHALL abort the operation; the pending result is discarded and no response is produced after release.
REQ-030 req0_ready/req1_ready SHALL be low while reset is high.

Verification
REQ-031 SETTLE_CYCLES=1, req0 only, a=43 b=112 -> accepted, rsp_valid one edge later with rsp_data=4816, rsp_id=0.
REQ-032 After reset both valid, req0 255x255, req1 43x112, rsp_ready=1 -> responses in order id0=65025 then id1=4816; req1_ready low until first response completes.
REQ-033 rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_data/rsp_id stable, both reqN_ready low, busy=1; completes on first rsp_ready edge.
REQ-034 reset pulsed while in CALC -> all outputs at reset values in the same cycle; no rsp_valid after release; next req0 0x200 -> rsp_data=0.
REQ-035 req1 alone for three consecutive operations -> granted each time (round-robin never starves a lone requester).
REQ-036 SETTLE_CYCLES=3, req1 15x17 -> rsp_valid exactly 3 edges after accept, rsp_data=255, mul_in1/mul_in2 stable at 15/17 throughout CALC.
